// File: rtl/width_downsizer.sv
// Splits each IN_W-bit word into IN_W/OUT_W OUT_W-bit chunks; optional packet-last tracking via WDS_LAST_EN.
// Latency: 1 clk from in_fire to first chunk on out_data; back-to-back words stream at 1 chunk/clk.
// Backpressure: out_ready low freezes the current chunk; in_ready only rises when the final chunk leaves.
module width_downsizer #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef WDS_LAST_EN
  ,
  input  logic             in_last,
  output logic             out_last
`endif
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_cfg
    $error("width_downsizer: IN_W must be an integer multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t          state;
  logic [IN_W-1:0] hold;
  logic [CW-1:0]   cnt;
  logic            cnt_last;
  logic            in_fire;

  // Chunk k in emission order; MSB_FIRST flips which slice of the word that is.
  function automatic logic [OUT_W-1:0] chunk_of(input logic [IN_W-1:0] w, input int k);
    int idx;
    idx = MSB_FIRST ? (RATIO - 1 - k) : k;
    return w[idx*OUT_W +: OUT_W];
  endfunction

  assign cnt_last = (cnt == LAST_IDX);
  assign in_ready = (state == EMPTY) || ((state == BUSY) && cnt_last && out_ready);
  assign in_fire  = in_valid && in_ready;

`ifdef WDS_LAST_EN
  logic last_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      hold      <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef WDS_LAST_EN
      last_q    <= 1'b0;
      out_last  <= 1'b0;
`endif
    end else if (in_fire) begin
      // Covers both the idle load and the seamless reload on the final chunk.
      state     <= BUSY;
      hold      <= in_data;
      cnt       <= '0;
      out_data  <= chunk_of(in_data, 0);
      out_valid <= 1'b1;
`ifdef WDS_LAST_EN
      last_q    <= in_last;
      out_last  <= 1'b0;
`endif
    end else if ((state == BUSY) && out_ready) begin
      if (cnt_last) begin
        state     <= EMPTY;
        cnt       <= '0;
        out_valid <= 1'b0;
`ifdef WDS_LAST_EN
        out_last  <= 1'b0;
`endif
      end else begin
        cnt      <= cnt + 1'b1;
        out_data <= chunk_of(hold, int'(cnt) + 1);
`ifdef WDS_LAST_EN
        out_last <= last_q && ((cnt + 1'b1) == LAST_IDX);
`endif
      end
    end
  end

endmodule

// File: tb/tb_width_downsizer.sv
// Bench for width_downsizer: vector table, random-backpressure streaming against a queue model, 32b and reset cases.
module tb_width_downsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0] a_in_data;  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_out_data;
  logic [15:0] b_in_data;  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_out_data;
  logic [31:0] c_in_data;  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0]  c_out_data;
`ifdef WDS_LAST_EN
  logic a_in_last, a_out_last, b_in_last, b_out_last, c_in_last, c_out_last;
`endif

  width_downsizer #(.IN_W(16), .OUT_W(8), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef WDS_LAST_EN
    , .in_last(a_in_last), .out_last(a_out_last)
`endif
  );

  width_downsizer #(.IN_W(16), .OUT_W(8), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef WDS_LAST_EN
    , .in_last(b_in_last), .out_last(b_out_last)
`endif
  );

  width_downsizer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready)
`ifdef WDS_LAST_EN
    , .in_last(c_in_last), .out_last(c_out_last)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        e_vld;
    logic [7:0]  e_dat;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[15];

  // Reference: chunks outstanding in a queue; busy while non-empty, ready when empty or the last one leaves.
  task automatic run_stream(input bit rnd, input string tag);
    logic [7:0] q[$];
    int widx  = 0;
    int rcv   = 0;
    int cyc   = 0;
    int first = -1;
    int last  = -1;
    bit exp_rdy;
    while (rcv < 1250 && cyc < 6000 && errors < 40) begin
      a_in_valid  = (widx < 625);
      a_in_data   = 16'(widx * 8);
      a_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && a_out_ready);
      chk({tag, "_in_ready"}, 32'(a_in_ready), 32'(exp_rdy));
      chk({tag, "_out_valid"}, 32'(a_out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk({tag, "_out_data"}, 32'(a_out_data), 32'(q[0]));
        if (a_out_ready) begin
          void'(q.pop_front());
          rcv++;
          if (first < 0) first = cyc;
          last = cyc;
        end
      end
      if (a_in_valid && exp_rdy) begin
        q.push_back(8'((widx * 8) % 256));
        q.push_back(8'((widx * 8) / 256));
        widx++;
      end
      tick();
      cyc++;
    end
    chk({tag, "_chunk_count"}, 32'(rcv), 32'd1250);
    if (!rnd) chk({tag, "_no_gap_span"}, 32'(last - first + 1), 32'd1250);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h34, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h12, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[5]  = '{1'b1, 16'hABCD, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[6]  = '{1'b1, 16'h5555, 1'b0, 1'b1, 8'hCD, 1'b0};
    tbl[7]  = '{1'b1, 16'h5555, 1'b1, 1'b1, 8'hCD, 1'b0};
    tbl[8]  = '{1'b1, 16'h5555, 1'b0, 1'b1, 8'hAB, 1'b0};
    tbl[9]  = '{1'b1, 16'h5555, 1'b1, 1'b1, 8'hAB, 1'b1};
    tbl[10] = '{1'b1, 16'h6677, 1'b1, 1'b1, 8'h55, 1'b0};
    tbl[11] = '{1'b1, 16'h6677, 1'b1, 1'b1, 8'h55, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h77, 1'b0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h66, 1'b1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
`ifdef WDS_LAST_EN
    a_in_last = 1'b0; b_in_last = 1'b0; c_in_last = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("reset_a_out_data", 32'(a_out_data), 32'h00);
    chk("reset_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("reset_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("reset_c_out_data", 32'(c_out_data), 32'h00);
    chk("reset_c_in_ready", 32'(c_in_ready), 32'd1);
`ifdef WDS_LAST_EN
    chk("reset_a_out_last", 32'(a_out_last), 32'd0);
`endif
    tick();

    for (int i = 0; i < 15; i++) begin
      a_in_valid  = tbl[i].iv;
      a_in_data   = tbl[i].id;
      a_out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(a_out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_in_ready", i), 32'(a_in_ready), 32'(tbl[i].e_rdy));
      if (tbl[i].e_vld) chk($sformatf("vec%0d_out_data", i), 32'(a_out_data), 32'(tbl[i].e_dat));
      tick();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;

    b_in_valid = 1'b1; b_in_data = 16'h1234; b_out_ready = 1'b1;
    #1;
    chk("msb_first_in_ready", 32'(b_in_ready), 32'd1);
    tick();
    b_in_valid = 1'b0;
    #1;
    chk("msb_first_c0_valid", 32'(b_out_valid), 32'd1);
    chk("msb_first_c0_data", 32'(b_out_data), 32'h12);
    tick();
    #1;
    chk("msb_first_c1_data", 32'(b_out_data), 32'h34);
    chk("msb_first_c1_in_ready", 32'(b_in_ready), 32'd1);
    tick();
    #1;
    chk("msb_first_done_valid", 32'(b_out_valid), 32'd0);
    tick();

    run_stream(1'b0, "stream_full");
    run_stream(1'b1, "stream_rand");
    tick();

    c_in_valid = 1'b1; c_in_data = 32'hA1B2C3D4; c_out_ready = 1'b1;
    #1;
    chk("w32_in_ready_idle", 32'(c_in_ready), 32'd1);
    tick();
    c_in_valid = 1'b0;
    #1;
    chk("w32_c0", 32'(c_out_data), 32'hD4);
    chk("w32_c0_valid", 32'(c_out_valid), 32'd1);
    tick(); #1;
    chk("w32_c1", 32'(c_out_data), 32'hC3);
    chk("w32_c1_in_ready", 32'(c_in_ready), 32'd0);
    tick(); #1;
    chk("w32_c2", 32'(c_out_data), 32'hB2);
    tick();
    c_in_valid = 1'b1; c_in_data = 32'h01020304;
    #1;
    chk("w32_c3", 32'(c_out_data), 32'hA1);
    chk("w32_c3_in_ready", 32'(c_in_ready), 32'd1);
    tick();
    c_in_valid = 1'b0;
    #1;
    chk("w32_wrap_valid", 32'(c_out_valid), 32'd1);
    chk("w32_wrap_c0", 32'(c_out_data), 32'h04);
    tick(); #1;
    chk("w32_second_c1", 32'(c_out_data), 32'h03);
    rst_n = 1'b0;
    #1;
    chk("w32_reset_valid", 32'(c_out_valid), 32'd0);
    chk("w32_reset_data", 32'(c_out_data), 32'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("w32_post_reset_valid%0d", i), 32'(c_out_valid), 32'd0);
      tick();
    end

`ifdef WDS_LAST_EN
    a_in_valid = 1'b1; a_in_data = 16'h1111; a_in_last = 1'b0; a_out_ready = 1'b1;
    tick();
    a_in_data = 16'h2222; a_in_last = 1'b1;
    #1;
    chk("last_w0c0", 32'({a_out_data, a_out_last}), 32'({8'h11, 1'b0}));
    tick(); #1;
    chk("last_w0c1", 32'({a_out_data, a_out_last}), 32'({8'h11, 1'b0}));
    tick();
    a_in_valid = 1'b0; a_in_last = 1'b0;
    #1;
    chk("last_w1c0", 32'({a_out_data, a_out_last}), 32'({8'h22, 1'b0}));
    tick(); #1;
    chk("last_w1c1", 32'({a_out_data, a_out_last, a_out_valid}), 32'({8'h22, 1'b1, 1'b1}));
    tick(); #1;
    chk("last_after", 32'({a_out_last, a_out_valid}), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
